// File: rtl/ultrasonic_range_meters.sv
// ============================================================================
// Module   : ultrasonic_range_meters
// Brief    : Triggers an ultrasonic ranger, times the echo in microseconds and
//            presents the distance in millimetres on a valid/ready handshake.
//            Define RANGE_FEET_OUT_EN to add dist_cft (hundredths of a foot).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ultrasonic_range_meters #(
    parameter int CLK_HZ     = 50000000,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        trig,
    input  logic        echo,
    output logic        busy,
    output logic [15:0] dist_mm,
    output logic        dist_timeout,
`ifdef RANGE_FEET_OUT_EN
    output logic [15:0] dist_cft,
`endif
    output logic        dist_valid,
    input  logic        dist_ready
);

    localparam int c_PRESCALE = CLK_HZ / 1000000;
    localparam int c_PRE_W    = $clog2(c_PRESCALE + 1);
    localparam int c_TRIG_CYC = TRIG_US * c_PRESCALE;
    localparam int c_TRIG_W   = $clog2(c_TRIG_CYC + 1);

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(c_PRESCALE - 1);
    localparam logic [c_TRIG_W-1:0] c_TRIG_LAST = c_TRIG_W'(c_TRIG_CYC - 1);
    localparam logic [15:0]         c_TO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]         c_MAX_MM    = 16'((64'(TIMEOUT_US) * 64'd11239) >> 16);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_CALC = 3'd4;
`ifdef RANGE_FEET_OUT_EN
    localparam logic [2:0] S_CONV = 3'd5;
`endif
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]          r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_echo_p;
    logic [c_PRE_W-1:0]  r_pre;
    logic [c_TRIG_W-1:0] r_tcnt;
    logic [15:0]         r_us;

    logic        w_echo_s;
    logic        w_tick;
    logic [31:0] w_prod;
    logic [15:0] w_mm_raw;
    logic [15:0] w_mm;

    assign w_echo_s = r_sync2;
    assign w_tick   = (r_pre == c_PRE_LAST);
    assign w_prod   = 32'(r_us) * 32'd11239;
    assign w_mm_raw = 16'(w_prod >> 16);
    assign w_mm     = (w_mm_raw > c_MAX_MM) ? 16'hFFFE : w_mm_raw;

`ifdef RANGE_FEET_OUT_EN
    logic [31:0] w_cprod;
    logic [15:0] w_cft;
    assign w_cprod = 32'(dist_mm) * 32'd21501;
    assign w_cft   = 16'(w_cprod >> 16);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_echo_p     <= 1'b0;
            r_pre        <= '0;
            r_tcnt       <= '0;
            r_us         <= '0;
            trig         <= 1'b0;
            busy         <= 1'b0;
            dist_mm      <= '0;
            dist_timeout <= 1'b0;
            dist_valid   <= 1'b0;
`ifdef RANGE_FEET_OUT_EN
            dist_cft     <= '0;
`endif
        end else begin
            r_sync1  <= echo;
            r_sync2  <= r_sync1;
            r_echo_p <= w_echo_s;
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_TRIG;
                        trig    <= 1'b1;
                        busy    <= 1'b1;
                        r_tcnt  <= '0;
                        r_pre   <= '0;
                    end
                end
                S_TRIG: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (r_tcnt == c_TRIG_LAST) begin
                        r_state <= S_WAIT;
                        trig    <= 1'b0;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end
                S_WAIT: begin
                    // an echo already high on entry never produces a rise here
                    if (w_echo_s && !r_echo_p) begin
                        r_state <= S_MEAS;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end else if (w_tick) begin
                        if (r_us == c_TO_LAST) begin
                            r_state      <= S_DONE;
                            dist_valid   <= 1'b1;
                            dist_mm      <= 16'hFFFF;
                            dist_timeout <= 1'b1;
`ifdef RANGE_FEET_OUT_EN
                            dist_cft     <= 16'hFFFF;
`endif
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                S_MEAS: begin
                    // The WAIT cycle that saw the rise was the echo's first
                    // high cycle, so the fall cycle still closes a period.
                    if (!w_echo_s) begin
                        r_state <= S_CALC;
                        if (w_tick) r_us <= r_us + 1'b1;
                    end else if (w_tick) begin
                        if (r_us == c_TO_LAST) begin
                            r_state      <= S_DONE;
                            dist_valid   <= 1'b1;
                            dist_mm      <= 16'hFFFF;
                            dist_timeout <= 1'b1;
`ifdef RANGE_FEET_OUT_EN
                            dist_cft     <= 16'hFFFF;
`endif
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    dist_mm      <= w_mm;
                    dist_timeout <= 1'b0;
`ifdef RANGE_FEET_OUT_EN
                    r_state      <= S_CONV;
`else
                    r_state      <= S_DONE;
                    dist_valid   <= 1'b1;
`endif
                end
`ifdef RANGE_FEET_OUT_EN
                S_CONV: begin
                    dist_cft   <= w_cft;
                    dist_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (dist_ready) begin
                        dist_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_range_meters.sv
// ============================================================================
// Module   : tb_ultrasonic_range_meters
// Brief    : Self-checking bench for ultrasonic_range_meters, compared against
//            a behavioural distance model. Honours RANGE_FEET_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ultrasonic_range_meters;

    localparam int CLK_HZ     = 2000000;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 6000;
    localparam int c_P        = CLK_HZ / 1000000;
`ifdef RANGE_FEET_OUT_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        echo = 1'b0;
    logic        dist_ready = 1'b0;
    logic        trig;
    logic        busy;
    logic [15:0] dist_mm;
    logic        dist_timeout;
    logic        dist_valid;
`ifdef RANGE_FEET_OUT_EN
    logic [15:0] dist_cft;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_armed = 1'b0;
    logic [15:0] exp_mm;
    logic [15:0] exp_cft;
    logic        exp_to;

    always #5 clk = ~clk;

    ultrasonic_range_meters #(
        .CLK_HZ    (CLK_HZ),
        .TRIG_US   (TRIG_US),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .trig        (trig),
        .echo        (echo),
        .busy        (busy),
        .dist_mm     (dist_mm),
        .dist_timeout(dist_timeout),
`ifdef RANGE_FEET_OUT_EN
        .dist_cft    (dist_cft),
`endif
        .dist_valid  (dist_valid),
        .dist_ready  (dist_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Result of an echo held high for h clock cycles; h < 0 means no usable
    // echo (none, or still high past the limit).
    function automatic void model(input int h, output logic [15:0] mm,
                                  output logic to, output logic [15:0] cft);
        longint us;
        longint v;
        longint vmax;
        if (h < 0 || (h - 1) >= TIMEOUT_US * c_P) begin
            mm  = 16'hFFFF;
            to  = 1'b1;
            cft = 16'hFFFF;
        end else begin
            us   = h / c_P;
            v    = (us * 11239) / 65536;
            vmax = (longint'(TIMEOUT_US) * 11239) / 65536;
            if (v > vmax) v = 65534;
            mm  = 16'(v);
            to  = 1'b0;
            cft = 16'((longint'(mm) * 21501) / 65536);
        end
    endfunction

    always @(negedge clk) begin
        if (dist_valid === 1'b1) begin
            if (!exp_armed) begin
                check("spurious_valid", 32'(dist_valid), 32'd0);
            end else begin
                check("dist_mm", 32'(dist_mm), 32'(exp_mm));
                check("dist_timeout", 32'(dist_timeout), 32'(exp_to));
                check("busy_with_valid", 32'(busy), 32'd1);
`ifdef RANGE_FEET_OUT_EN
                check("dist_cft", 32'(dist_cft), 32'(exp_cft));
`endif
            end
        end
    end

    // Issues start from IDLE and returns at the negedge where trig has fallen.
    task automatic fire(input string tag);
        int n;
        @(negedge clk);
        check({tag, "_trig_idle"}, 32'(trig), 32'd0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_trig_rise"}, 32'(trig), 32'd1);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (trig === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_trig_width"}, 32'(n), 32'(TRIG_US * c_P));
    endtask

    // h > 0: echo high for h cycles; h == 0: no echo; h < 0: echo stuck high
    task automatic measure(input string tag, input int dly, input int h,
                           input int lag, input bit poke_start);
        int n;
        int lat;
        logic [15:0] mm;
        logic [15:0] cft;
        logic        to;
        model((h <= 0) ? -1 : h, mm, to, cft);
        fire(tag);
        exp_mm = mm; exp_to = to; exp_cft = cft; exp_armed = 1'b1;
        n = 0;
        if (h == 0) begin
            lat = TIMEOUT_US * c_P;
        end else begin
            @(posedge clk);
            repeat (dly) @(posedge clk);
            #1 echo = 1'b1;
            if (h < 0) begin
                lat = 3 + TIMEOUT_US * c_P;
            end else begin
                for (int i = 0; i < h; i++) begin
                    @(posedge clk); #1;
                    start = poke_start && (i == h / 2);
                    if (poke_start) check({tag, "_no_retrig"}, 32'(trig), 32'd0);
                end
                start = 1'b0;
                echo  = 1'b0;
                lat   = 4 + c_EXTRA;
            end
        end
        while (dist_valid !== 1'b1 && n < lat + 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        for (int i = 0; i < lag; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(dist_valid), 32'd1);
        end
        dist_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        dist_ready = 1'b0;
        start      = 1'b0;
        exp_armed  = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(dist_valid), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_accept_start_ignored"}, 32'(trig), 32'd0);
        end
        #1 echo = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mm;
        logic [15:0] cft;
        logic        to;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dist_mm", 32'(dist_mm), 32'd0);
        check("rst_timeout", 32'(dist_timeout), 32'd0);
        check("rst_valid", 32'(dist_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        model(5832 * c_P, mm, to, cft);
        check("model_nominal_mm", 32'(mm), 32'd1000);
        check("model_nominal_cft", 32'(cft), 32'd328);
        model(1, mm, to, cft);
        check("model_short_mm", 32'(mm), 32'd0);
        model(-1, mm, to, cft);
        check("model_timeout_mm", 32'(mm), 32'hFFFF);
        check("model_timeout_flag", 32'(to), 32'd1);

        // 100 us after trig, 5832 us echo, consumer stalls 5 cycles
        measure("nominal", 100 * c_P - 1, 5832 * c_P, 5, 1'b0);
        check("nominal_mm_literal", 32'(dist_mm), 32'd1000);
        measure("no_echo", 0, 0, 0, 1'b0);
        check("no_echo_mm_literal", 32'(dist_mm), 32'hFFFF);
        measure("stuck", 10, -1, 1, 1'b0);
        check("stuck_timeout_literal", 32'(dist_timeout), 32'd1);
        measure("short", 3, 1, 0, 1'b0);
        check("short_mm_literal", 32'(dist_mm), 32'd0);
        measure("poke", 7, 400, 2, 1'b0);
        measure("poke_start", 7, 400, 0, 1'b1);

        // reset in the middle of a measurement
        fire("rstmeas");
        exp_armed = 1'b0;
        @(posedge clk); #1 echo = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmeas_trig", 32'(trig), 32'd0);
        check("rstmeas_busy", 32'(busy), 32'd0);
        check("rstmeas_valid", 32'(dist_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1 echo = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rstmeas_idle_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            measure("rand", int'($urandom_range(0, 40)), int'($urandom_range(1, 2400)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
